// File: rtl/ctrl_addrgen.sv
// ctrl_addrgen: per-vector MAC address generator and result-write sequencer.
// Walks the data ring downward from the upper pointer and the coefficient
// array upward from its base, one tap per cycle, then waits out the MAC
// pipeline and writes the result and error registers before asking for the
// next instruction word.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; captured fields and addresses hold
//   RUN    | one tap per cycle, RAM read enabled
//   DRAIN  | MAC pipeline flushing, MACLAT cycles
//   WR_RES | write result register
//   WR_ERR | write error register, request next word, stage/frame pulses
module ctrl_addrgen #(
   parameter int VIDWIDTH = 5,
   parameter int RFAWIDTH = 5,
   parameter int DAWIDTH  = 12,
   parameter int MACLAT   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                lstg_f,
   input  logic                upse_f,
   input  logic [VIDWIDTH-1:0] vector_id,
   input  logic [RFAWIDTH-1:0] result_reg,
   input  logic [RFAWIDTH-1:0] error_reg,
   input  logic [DAWIDTH-1:0]  data_uptr,
   input  logic [DAWIDTH-1:0]  data_lptr,
   input  logic [DAWIDTH-1:0]  coef_ptr,
   output logic                busy,
   output logic                ram_re,
   output logic [DAWIDTH-1:0]  data_addr,
   output logic [DAWIDTH-1:0]  coef_addr,
   output logic                mac_first,
   output logic                mac_last,
   output logic                rf_we,
   output logic [RFAWIDTH-1:0] rf_waddr,
   output logic [VIDWIDTH-1:0] vid_out,
   output logic                fetch,
   output logic                stage_done,
   output logic                frame_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_DRAIN  = 3'd2,
      S_WR_RES = 3'd3,
      S_WR_ERR = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [DAWIDTH-1:0]  data_addr_q;
   logic [DAWIDTH-1:0]  coef_addr_q;
   logic [DAWIDTH-1:0]  lptr_q;
   logic [RFAWIDTH-1:0] result_q;
   logic [RFAWIDTH-1:0] error_q;
   logic [VIDWIDTH-1:0] vid_q;
   logic                lstg_q;
   logic                upse_q;
   logic                first_q;
   logic [3:0]          drain_cnt;

   logic accept;
   logic tap_last;

   assign accept   = (state == S_IDLE) && start;
   // The data pointer walks down to the lower pointer, so reaching it marks the final tap.
   assign tap_last = (state == S_RUN) && (data_addr_q == lptr_q);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_RUN;
         S_RUN:    if (tap_last) state_nxt = S_DRAIN;
         S_DRAIN:  if (drain_cnt == 4'd0) state_nxt = S_WR_RES;
         S_WR_RES: state_nxt = S_WR_ERR;
         S_WR_ERR: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Field capture, tap address stepping and drain down-counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_addr_q <= '0;
         coef_addr_q <= '0;
         lptr_q      <= '0;
         result_q    <= '0;
         error_q     <= '0;
         vid_q       <= '0;
         lstg_q      <= 1'b0;
         upse_q      <= 1'b0;
         first_q     <= 1'b0;
         drain_cnt   <= '0;
      end else if (accept) begin
         data_addr_q <= data_uptr;
         coef_addr_q <= coef_ptr;
         lptr_q      <= data_lptr;
         result_q    <= result_reg;
         error_q     <= error_reg;
         vid_q       <= vector_id;
         lstg_q      <= lstg_f;
         upse_q      <= upse_f;
         first_q     <= 1'b1;
      end else if (state == S_RUN) begin
         first_q <= 1'b0;
         if (tap_last) begin
            drain_cnt <= 4'(MACLAT - 1);
         end else begin
            data_addr_q <= data_addr_q - 1'b1;
            coef_addr_q <= coef_addr_q + 1'b1;
         end
      end else if ((state == S_DRAIN) && (drain_cnt != 4'd0)) begin
         drain_cnt <= drain_cnt - 4'd1;
      end
   end

   // Per-state output decode; strobes are purely state-derived so reset clears them at once.
   always_comb begin
      busy       = (state != S_IDLE);
      ram_re     = 1'b0;
      mac_first  = 1'b0;
      mac_last   = 1'b0;
      rf_we      = 1'b0;
      rf_waddr   = '0;
      fetch      = 1'b0;
      stage_done = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_RUN: begin
            ram_re    = 1'b1;
            mac_first = first_q;
            mac_last  = tap_last;
         end
         S_WR_RES: begin
            rf_we    = 1'b1;
            rf_waddr = result_q;
         end
         S_WR_ERR: begin
            rf_we      = 1'b1;
            rf_waddr   = error_q;
            fetch      = 1'b1;
            stage_done = lstg_q;
            frame_done = upse_q;
         end
         default: ;
      endcase
   end

   assign data_addr = data_addr_q;
   assign coef_addr = coef_addr_q;
   assign vid_out   = vid_q;

endmodule

// File: tb/tb_ctrl_addrgen.sv
module tb_ctrl_addrgen;
   localparam int VW = 5;
   localparam int RW = 5;
   localparam int DW = 12;
   localparam int ML = 3;
   localparam int AM = 1 << DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic lstg_f = 1'b0, upse_f = 1'b0;
   logic [VW-1:0] vector_id = '0;
   logic [RW-1:0] result_reg = '0, error_reg = '0;
   logic [DW-1:0] data_uptr = '0, data_lptr = '0, coef_ptr = '0;
   logic busy, ram_re, mac_first, mac_last, rf_we, fetch, stage_done, frame_done;
   logic [DW-1:0] data_addr, coef_addr;
   logic [RW-1:0] rf_waddr;
   logic [VW-1:0] vid_out;

   int vectors = 0;
   int errors  = 0;

   // model state: fields of the vector currently expected to be in flight
   int cur_u = 0, cur_l = 0, cur_c = 0, cur_res = 0, cur_err = 0, cur_ls = 0, cur_up = 0, cur_vid = 0;
   int hold_da = 0, hold_ca = 0;

   ctrl_addrgen #(.VIDWIDTH(VW), .RFAWIDTH(RW), .DAWIDTH(DW), .MACLAT(ML)) dut (
      .clk(clk), .rst(rst), .start(start), .lstg_f(lstg_f), .upse_f(upse_f),
      .vector_id(vector_id), .result_reg(result_reg), .error_reg(error_reg),
      .data_uptr(data_uptr), .data_lptr(data_lptr), .coef_ptr(coef_ptr),
      .busy(busy), .ram_re(ram_re), .data_addr(data_addr), .coef_addr(coef_addr),
      .mac_first(mac_first), .mac_last(mac_last), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .vid_out(vid_out), .fetch(fetch), .stage_done(stage_done), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   wire [41:0] obs = {busy, ram_re, mac_first, mac_last, rf_we, fetch, stage_done, frame_done,
                      data_addr, coef_addr, rf_waddr, vid_out};

   function automatic int wrap(int x);
      return ((x % AM) + AM) % AM;
   endfunction

   function automatic int taps();
      return wrap(cur_u - cur_l) + 1;
   endfunction

   // Expected outputs k cycles after acceptance (k = 0: idle with no vector since reset).
   function automatic logic [41:0] model(int k);
      int n;
      logic [7:0] f;
      logic [11:0] da, ca;
      logic [4:0] wa;
      n  = taps();
      f  = 8'h00;
      wa = 5'd0;
      if (k == 0) begin
         da = 12'(hold_da); ca = 12'(hold_ca);
      end else if (k <= n) begin
         f  = {1'b1, 1'b1, (k == 1), (k == n), 4'b0000};
         da = 12'(wrap(cur_u - (k - 1)));
         ca = 12'(wrap(cur_c + k - 1));
      end else begin
         da = 12'(cur_l);
         ca = 12'(wrap(cur_c + n - 1));
         if (k <= n + ML) f = 8'b1000_0000;
         else if (k == n + ML + 1) begin
            f = 8'b1000_1000; wa = 5'(cur_res);
         end else if (k == n + ML + 2) begin
            f = {1'b1, 3'b000, 1'b1, 1'b1, 1'(cur_ls), 1'(cur_up)}; wa = 5'(cur_err);
         end
      end
      return {f, da, ca, wa, 5'(cur_vid)};
   endfunction

   task automatic load(int u, int l, int c, int res, int err, int ls, int up, int vid, bit commit);
      data_uptr = 12'(u); data_lptr = 12'(l); coef_ptr = 12'(c);
      result_reg = 5'(res); error_reg = 5'(err);
      lstg_f = 1'(ls); upse_f = 1'(up); vector_id = 5'(vid);
      if (commit) begin
         cur_u = wrap(u); cur_l = wrap(l); cur_c = wrap(c);
         cur_res = res & 31; cur_err = err & 31; cur_ls = ls & 1; cur_up = up & 1; cur_vid = vid & 31;
      end
   endtask

   task automatic test_reset();
      logic [41:0] e;
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         e = model(0);
         vectors++;
         if (obs !== e) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
      end
      start = 1'b0;
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         e = model(0);
         vectors++;
         if (obs !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
      end
   endtask

   task automatic test_directed();
      int tbl [5][8] = '{
         '{10, 7, 100, 3, 4, 0, 0, 17},
         '{1, 4094, 2000, 9, 10, 0, 1, 5},
         '{5, 5, 4095, 21, 22, 1, 1, 30},
         '{300, 296, 4093, 12, 13, 1, 0, 8},
         '{0, 4095, 0, 31, 0, 0, 0, 31}};
      logic [41:0] e;
      int L;
      foreach (tbl[i]) begin
         load(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5], tbl[i][6], tbl[i][7], 1'b1);
         start = 1'b1;
         @(posedge clk);
         L = taps() + ML + 2;
         for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            e = model(k);
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL directed[%0d] k=%0d got=%h exp=%h", i, k, obs, e); end
            start = 1'b0;
         end
      end
   endtask

   task automatic test_random();
      logic [41:0] e;
      int L, l;
      for (int v = 0; v < 30; v++) begin
         l = $urandom_range(0, AM - 1);
         load(l + $urandom_range(0, 20), l, $urandom_range(0, AM - 1), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), 1'b1);
         start = 1'b1;
         @(posedge clk);
         L = taps() + ML + 2;
         for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            e = model(k);
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL random[%0d] k=%0d got=%h exp=%h", v, k, obs, e); end
            if (k <= L) begin
               // busy-time start pulses with junk fields must not disturb the vector
               start = 1'($urandom_range(0, 1));
               load($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b0);
            end else begin
               start = 1'b0;
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [41:0] e;
      int L;
      load(40, 37, 50, 1, 2, 1, 0, 11, 1'b1);
      start = 1'b1;
      @(posedge clk);
      for (int pass = 0; pass < 2; pass++) begin
         L = taps() + ML + 2;
         for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            e = model(k);
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL back_to_back[%0d] k=%0d got=%h exp=%h", pass, k, obs, e); end
            if (k == L) begin
               if (pass == 0) load(7, 6, 4094, 3, 4, 0, 1, 12, 1'b0);
               else start = 1'b0;
            end
         end
         if (pass == 0) begin
            load(7, 6, 4094, 3, 4, 0, 1, 12, 1'b1);
            @(posedge clk);
         end
      end
      hold_da = cur_l; hold_ca = wrap(cur_c + taps() - 1);
      @(negedge clk);
      e = model(0);
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL back_to_back_idle got=%h exp=%h", obs, e); end
   endtask

   task automatic test_reset_drain();
      logic [41:0] e;
      int L;
      load(20, 15, 7, 5, 6, 1, 1, 19, 1'b1);
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= taps() + 2; k++) begin
         @(negedge clk);
         e = model(k);
         vectors++;
         if (obs !== e) begin errors++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k, obs, e); end
         start = 1'b0;
      end
      rst = 1'b1;
      start = 1'b1;
      #1;
      vectors++;
      if (obs !== 42'd0) begin errors++; $display("FAIL reset_immediate got=%h exp=%h", obs, 42'd0); end
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (obs !== 42'd0) begin errors++; $display("FAIL reset_abort got=%h exp=%h", obs, 42'd0); end
      end
      rst = 1'b0;
      start = 1'b0;
      hold_da = 0; hold_ca = 0; cur_vid = 0;
      @(negedge clk);
      e = model(0);
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL post_reset_idle got=%h exp=%h", obs, e); end
      load(3, 1, 9, 14, 15, 0, 1, 2, 1'b1);
      start = 1'b1;
      @(posedge clk);
      L = taps() + ML + 2;
      for (int k = 1; k <= L + 1; k++) begin
         @(negedge clk);
         e = model(k);
         vectors++;
         if (obs !== e) begin errors++; $display("FAIL post_reset_vec k=%0d got=%h exp=%h", k, obs, e); end
         start = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
